interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
Standalone, parametrised interrupt controller that replaces the fixed 5-source IF/IE logic embedded in the CPU core.
- Holds the IF (flag) and IE (enable) registers, both memory-mapped on the peripheral bus.
- Owns the IME state machine, including the one-instruction EI delay.
- Resolves fixed-priority dispatch at CPU instruction boundaries and provides a HALT wake signal.
- Sits between the peripherals (PPU, timer, serial, joypad, future sources) and the CPU control-word sequencer.

Parameters:
- NUM_SOURCES, 5, number of interrupt lines (1..8); bit 0 is the highest priority.
- IF_ADDR, 16'hFF0F, bus address of the IF register.
- IE_ADDR, 16'hFFFF, bus address of the IE register.
- VECTOR_BASE, 16'h0040, dispatch address for source 0.
- VECTOR_STRIDE, 8, byte spacing between consecutive vectors.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- bus_addr  in  16  peripheral bus address
- bus_wdata  in  8  peripheral bus write data
- bus_write_en  in  1  bus write strobe
- bus_read_en  in  1  bus read strobe
- bus_rdata  out  8  read data (combinational)
- irq_req  in  NUM_SOURCES  per-source request from peripherals
- instr_boundary  in  1  CPU retired an instruction this cycle
- ei_exec  in  1  EI retired (asserted with instr_boundary)
- di_exec  in  1  DI retired
- reti_exec  in  1  RETI retired
- irq_take  out  1  one-cycle dispatch pulse
- irq_index  out  3  index of the dispatched source
- irq_vector  out  16  dispatch vector address
- wake  out  1  registered; exit HALT
- ime  out  1  current IME

Behaviour:
Reset state:
- IF bits [NUM_SOURCES-1:0] = 0; IE = 8'h00.
- IME state = IME_OFF.
- irq_take = 0, irq_index = 0, irq_vector = VECTOR_BASE, wake = 0, ime = 0.

Register access:
- IF reads: bits at or above NUM_SOURCES read as 1.
- IF writes: update only bits below NUM_SOURCES.
- IE: full 8-bit read/write; only the low NUM_SOURCES bits participate in dispatch.
- bus_rdata = 8'h00 when bus_read_en is low or the address matches neither register.

IF set/clear priority, all within the same cycle:
- A request always beats a clear. An irq_req bit high sets its IF bit even if a bus write of 0 or a dispatch clear targets that bit in the same cycle.
- A dispatch clear beats a bus write of 1.

IME state machine (IME_OFF, IME_ARMED, IME_ON):
- From OFF, ei_exec -> ARMED.
- From ARMED, the next instr_boundary without ei_exec -> ON. This is the one-instruction EI delay.
- reti_exec -> ON immediately, from any state.
- di_exec -> OFF immediately, from any state; DI takes precedence if asserted together with EI or RETI.
- A dispatch -> OFF.
- ime output = (state == IME_ON).

Dispatch:
- pending = IF & IE[NUM_SOURCES-1:0].
- Condition: instr_boundary && state == IME_ON && pending != 0.
- Selects the lowest set pending bit k.
- Next edge: irq_take = 1 for exactly one cycle, irq_index = k, irq_vector = VECTOR_BASE + k*VECTOR_STRIDE (16-bit, no overflow for legal parameters). On the same edge IF[k] clears and the state goes to OFF.
- irq_index and irq_vector hold their values until the next dispatch.
- No dispatch while ARMED, even if pending is set. Dispatch latency from a qualifying boundary is 1 cycle.

Wake:
- Next-cycle value of wake = (pending != 0), independent of IME.

Reset mid-operation:
- Returns all state to reset values on the next edge, including a pending ARMED state or an in-flight irq_take.

Optional Feature:
Macro INTC_IRQ_EDGE_DETECT_EN.
- Defined: irq_req is sampled into a NUM_SOURCES-wide register (reset 0); an IF bit is set only on a 0->1 transition, so a held-high line sets the flag once.
- Undefined: every cycle that irq_req[i] is high sets IF[i] (level behaviour, identical to the current CPU-embedded logic).

Decomposition:
Package intc_pkg:
- ime_state_t enum.
- INTC_MAX_SOURCES = 8.
- Default address constants IF_ADDR_DEFAULT and IE_ADDR_DEFAULT.
- Vector base/stride defaults.

Sub-module intc_priority_enc:
- Purely combinational; takes a NUM_SOURCES-wide vector and outputs valid plus a 3-bit lowest-set index.
- Instantiated once for dispatch.

Test Plan:
1. Reset, then read IF_ADDR with NUM_SOURCES=5 -> 8'hE0; read IE_ADDR -> 8'h00; ime=0, irq_take=0.
2. IE=8'h1F, RETI, pulse irq_req=5'b00101, then instr_boundary -> irq_take one cycle, irq_index=0, irq_vector=16'h0040; IF reads 8'hE4; ime=0.
3. EI at boundary N with IF=1/IE=1 pending -> no dispatch at N+1's boundary consumption; IME goes ON at the next boundary, dispatch on the boundary after that (vector 16'h0040).
4. Bus write IF=8'h00 in the same cycle as irq_req[2]=1 -> IF reads 8'hE4 (request wins).
5. IME_OFF, IE=8'h04, irq_req[2] pulse -> wake=1 one cycle later, no irq_take.
6. NUM_SOURCES=8, VECTOR_STRIDE=8, pending only bit 7 with IME on at boundary -> irq_index=7, irq_vector=16'h0078; with INTC_IRQ_EDGE_DETECT_EN, a held irq_req[7] after the IF clear does not re-set IF.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared types and default constants for the interrupt controller.
package intc_pkg;

    localparam int          INTC_MAX_SOURCES      = 8;
    localparam logic [15:0] IF_ADDR_DEFAULT       = 16'hFF0F;
    localparam logic [15:0] IE_ADDR_DEFAULT       = 16'hFFFF;
    localparam logic [15:0] VECTOR_BASE_DEFAULT   = 16'h0040;
    localparam int          VECTOR_STRIDE_DEFAULT = 8;

    typedef enum logic [1:0] {
        IME_OFF   = 2'd0,
        IME_ARMED = 2'd1,
        IME_ON    = 2'd2
    } ime_state_t;

endpackage

// File: rtl/intc_priority_enc.sv
// Combinational lowest-set-bit encoder; bit 0 has the highest priority.
module intc_priority_enc #(
    parameter int NUM_SOURCES = 5
) (
    input  logic [NUM_SOURCES-1:0] i_vec,
    output logic                   o_valid,
    output logic [2:0]             o_index
);

    always_comb begin
        o_valid = |i_vec;
        o_index = 3'd0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (i_vec[i]) o_index = 3'(i);
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// IF/IE registers, IME state machine and fixed-priority dispatch for the CPU.
// Optional macro INTC_IRQ_EDGE_DETECT_EN: IF bits set on irq_req rising edges only.
//
// state     | meaning
// IME_OFF   | interrupts masked
// IME_ARMED | EI retired, IME turns on after the next instruction
// IME_ON    | interrupts enabled, dispatch at instruction boundaries
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int          NUM_SOURCES   = 5,
    parameter logic [15:0] IF_ADDR       = IF_ADDR_DEFAULT,
    parameter logic [15:0] IE_ADDR       = IE_ADDR_DEFAULT,
    parameter logic [15:0] VECTOR_BASE   = VECTOR_BASE_DEFAULT,
    parameter int          VECTOR_STRIDE = VECTOR_STRIDE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [15:0]            bus_addr,
    input  logic [7:0]             bus_wdata,
    input  logic                   bus_write_en,
    input  logic                   bus_read_en,
    output logic [7:0]             bus_rdata,
    input  logic [NUM_SOURCES-1:0] irq_req,
    input  logic                   instr_boundary,
    input  logic                   ei_exec,
    input  logic                   di_exec,
    input  logic                   reti_exec,
    output logic                   irq_take,
    output logic [2:0]             irq_index,
    output logic [15:0]            irq_vector,
    output logic                   wake,
    output logic                   ime
);

    ime_state_t             r_state;
    ime_state_t             w_state_next;
    logic [NUM_SOURCES-1:0] r_if;
    logic [7:0]             r_ie;
    logic                   r_take;
    logic [2:0]             r_index;
    logic [15:0]            r_vector;
    logic                   r_wake;

    logic [NUM_SOURCES-1:0] w_pending;
    logic [NUM_SOURCES-1:0] w_set;
    logic [NUM_SOURCES-1:0] w_clr_mask;
    logic [NUM_SOURCES-1:0] w_if_next;
    logic [7:0]             w_if_rd;
    logic                   w_valid;
    logic [2:0]             w_idx;
    logic                   w_dispatch;
    logic                   w_if_wr;
    logic                   w_ie_wr;

    assign w_pending  = r_if & r_ie[NUM_SOURCES-1:0];
    assign w_dispatch = instr_boundary && (r_state == IME_ON) && w_valid;
    assign w_if_wr    = bus_write_en && (bus_addr == IF_ADDR);
    assign w_ie_wr    = bus_write_en && (bus_addr == IE_ADDR);
    assign w_clr_mask = w_dispatch ? (NUM_SOURCES'(1) << w_idx) : '0;

    intc_priority_enc #(.NUM_SOURCES(NUM_SOURCES)) u_prio (
        .i_vec   (w_pending),
        .o_valid (w_valid),
        .o_index (w_idx)
    );

`ifdef INTC_IRQ_EDGE_DETECT_EN
    logic [NUM_SOURCES-1:0] r_irq_prev;

    always_ff @(posedge clk) begin
        if (reset) r_irq_prev <= '0;
        else       r_irq_prev <= irq_req;
    end

    assign w_set = irq_req & ~r_irq_prev;
`else
    assign w_set = irq_req;
`endif

    // Bus write first, then dispatch clear, then requests: requests always win.
    always_comb begin
        w_if_next = r_if;
        if (w_if_wr) w_if_next = bus_wdata[NUM_SOURCES-1:0];
        w_if_next = (w_if_next & ~w_clr_mask) | w_set;
    end

    always_comb begin
        w_state_next = r_state;
        if (di_exec)          w_state_next = IME_OFF;
        else if (w_dispatch)  w_state_next = IME_OFF;
        else if (reti_exec)   w_state_next = IME_ON;
        else begin
            case (r_state)
                IME_OFF:   if (ei_exec) w_state_next = IME_ARMED;
                IME_ARMED: if (instr_boundary && !ei_exec) w_state_next = IME_ON;
                default:   w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IME_OFF;
            r_if     <= '0;
            r_ie     <= 8'h00;
            r_take   <= 1'b0;
            r_index  <= 3'd0;
            r_vector <= VECTOR_BASE;
            r_wake   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_if    <= w_if_next;
            r_take  <= w_dispatch;
            r_wake  <= |w_pending;
            if (w_ie_wr) r_ie <= bus_wdata;
            if (w_dispatch) begin
                r_index  <= w_idx;
                r_vector <= VECTOR_BASE + 16'(w_idx) * 16'(VECTOR_STRIDE);
            end
        end
    end

    always_comb begin
        w_if_rd = 8'hFF;
        w_if_rd[NUM_SOURCES-1:0] = r_if;
    end

    always_comb begin
        bus_rdata = 8'h00;
        if (bus_read_en) begin
            if (bus_addr == IF_ADDR)      bus_rdata = w_if_rd;
            else if (bus_addr == IE_ADDR) bus_rdata = r_ie;
        end
    end

    assign irq_take   = r_take;
    assign irq_index  = r_index;
    assign irq_vector = r_vector;
    assign wake       = r_wake;
    assign ime        = (r_state == IME_ON);

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomized bench for interrupt_controller against a cycle-level reference model,
// plus directed scenarios and an 8-source instance for the top-priority-index case.
module tb_interrupt_controller;

    localparam logic [7:0]  MASK5   = 8'h1F;
    localparam logic [15:0] A_IF    = 16'hFF0F;
    localparam logic [15:0] A_IE    = 16'hFFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [15:0] bus_addr = '0;
    logic [7:0]  bus_wdata = '0;
    logic        bus_write_en = 1'b0, bus_read_en = 1'b0;
    logic [7:0]  bus_rdata;
    logic [4:0]  irq_req = '0;
    logic        instr_boundary = 1'b0, ei_exec = 1'b0, di_exec = 1'b0, reti_exec = 1'b0;
    logic        irq_take, wake, ime;
    logic [2:0]  irq_index;
    logic [15:0] irq_vector;

    logic        d8_reset = 1'b1;
    logic [15:0] d8_addr = '0;
    logic [7:0]  d8_wdata = '0;
    logic        d8_we = 1'b0, d8_re = 1'b0;
    logic [7:0]  d8_rdata;
    logic [7:0]  d8_req = '0;
    logic        d8_bnd = 1'b0, d8_ei = 1'b0, d8_di = 1'b0, d8_reti = 1'b0;
    logic        d8_take, d8_wake, d8_ime;
    logic [2:0]  d8_index;
    logic [15:0] d8_vector;

    interrupt_controller dut (
        .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_write_en(bus_write_en), .bus_read_en(bus_read_en), .bus_rdata(bus_rdata),
        .irq_req(irq_req), .instr_boundary(instr_boundary), .ei_exec(ei_exec),
        .di_exec(di_exec), .reti_exec(reti_exec), .irq_take(irq_take),
        .irq_index(irq_index), .irq_vector(irq_vector), .wake(wake), .ime(ime)
    );

    interrupt_controller #(.NUM_SOURCES(8)) dut8 (
        .clk(clk), .reset(d8_reset), .bus_addr(d8_addr), .bus_wdata(d8_wdata),
        .bus_write_en(d8_we), .bus_read_en(d8_re), .bus_rdata(d8_rdata),
        .irq_req(d8_req), .instr_boundary(d8_bnd), .ei_exec(d8_ei),
        .di_exec(d8_di), .reti_exec(d8_reti), .irq_take(d8_take),
        .irq_index(d8_index), .irq_vector(d8_vector), .wake(d8_wake), .ime(d8_ime)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: what the DUT outputs should show after the last edge.
    logic [7:0]  m_if = '0, m_ie = '0;
    int          m_ime = 0;           // 0 = off, 1 = armed, 2 = on
    logic        m_take = 1'b0, m_wake = 1'b0;
    int          m_idx = 0;
    logic [15:0] m_vec = 16'h0040;
    logic [4:0]  m_prev = '0;

    task automatic model_step(input logic rst, input logic [15:0] addr, input logic [7:0] wd,
                              input logic we, input logic [4:0] req, input logic bnd,
                              input logic ei, input logic di, input logic reti);
        logic [7:0] pend, nif;
        logic [4:0] set;
        logic       disp, found;
        int         k;
        if (rst) begin
            m_if = '0; m_ie = '0; m_ime = 0; m_take = 0; m_idx = 0;
            m_vec = 16'h0040; m_wake = 0; m_prev = '0;
            return;
        end
        pend = m_if & m_ie & MASK5;
        disp = bnd && (m_ime == 2) && (pend != 0);
        k = 0; found = 0;
        for (int i = 0; i < 5; i++) if (pend[i] && !found) begin k = i; found = 1; end
`ifdef INTC_IRQ_EDGE_DETECT_EN
        set = req & ~m_prev;
`else
        set = req;
`endif
        nif = m_if;
        if (we && addr == A_IF) nif = wd & MASK5;
        if (disp) nif[k] = 1'b0;
        nif = nif | {3'b000, set};
        if (we && addr == A_IE) m_ie = wd;
        if (di)                             m_ime = 0;
        else if (disp)                      m_ime = 0;
        else if (reti)                      m_ime = 2;
        else if (m_ime == 0 && ei)          m_ime = 1;
        else if (m_ime == 1 && bnd && !ei)  m_ime = 2;
        m_take = disp;
        if (disp) begin
            m_idx = k;
            m_vec = 16'h0040 + 16'(8 * k);
        end
        m_wake = (pend != 0);
        m_prev = req;
        m_if   = nif;
    endtask

    // Drive one cycle's inputs, compare all outputs with the model, then advance the model.
    task automatic cyc(input logic rst, input logic [15:0] addr, input logic [7:0] wd,
                       input logic we, input logic re, input logic [4:0] req,
                       input logic bnd, input logic ei, input logic di, input logic reti);
        logic [7:0] exp_rd;
        @(negedge clk);
        reset = rst; bus_addr = addr; bus_wdata = wd; bus_write_en = we; bus_read_en = re;
        irq_req = req; instr_boundary = bnd; ei_exec = ei; di_exec = di; reti_exec = reti;
        #1;
        exp_rd = 8'h00;
        if (re && addr == A_IF)      exp_rd = m_if | ~MASK5;
        else if (re && addr == A_IE) exp_rd = m_ie;
        check("rdata",  32'(bus_rdata),  32'(exp_rd));
        check("take",   32'(irq_take),   32'(m_take));
        check("index",  32'(irq_index),  32'(m_idx));
        check("vector", 32'(irq_vector), 32'(m_vec));
        check("wake",   32'(wake),       32'(m_wake));
        check("ime",    32'(ime),        32'(m_ime == 2));
        model_step(rst, addr, wd, we, req, bnd, ei, di, reti);
    endtask

    task automatic idle(input logic re, input logic [15:0] addr);
        cyc(0, addr, 8'h00, 0, re, 5'b0, 0, 0, 0, 0);
    endtask

    task automatic cyc8(input logic rst, input logic [15:0] addr, input logic [7:0] wd,
                        input logic we, input logic re, input logic [7:0] req,
                        input logic bnd, input logic reti);
        @(negedge clk);
        d8_reset = rst; d8_addr = addr; d8_wdata = wd; d8_we = we; d8_re = re;
        d8_req = req; d8_bnd = bnd; d8_ei = 0; d8_di = 0; d8_reti = reti;
        #1;
    endtask

    initial begin
        logic [7:0] exp_held;

        // Reset state
        cyc(1, 16'h0, 8'h00, 0, 0, 5'b0, 0, 0, 0, 0);
        idle(1, A_IF);
        check("reset_if_read", 32'(bus_rdata), 32'h0E0);
        check("reset_take", 32'(irq_take), 32'h0);
        check("reset_vector", 32'(irq_vector), 32'h0040);
        idle(1, A_IE);
        check("reset_ie_read", 32'(bus_rdata), 32'h00);
        check("reset_ime", 32'(ime), 32'h0);

        // RETI enables, two requests, lowest index dispatched
        cyc(0, A_IE, 8'h1F, 1, 0, 5'b0, 0, 0, 0, 0);
        cyc(0, 16'h0, 8'h00, 0, 0, 5'b0, 1, 0, 0, 1);
        cyc(0, 16'h0, 8'h00, 0, 0, 5'b00101, 0, 0, 0, 0);
        cyc(0, 16'h0, 8'h00, 0, 0, 5'b0, 1, 0, 0, 0);
        idle(1, A_IF);
        check("disp_take", 32'(irq_take), 32'h1);
        check("disp_index", 32'(irq_index), 32'h0);
        check("disp_vector", 32'(irq_vector), 32'h0040);
        check("disp_if_read", 32'(bus_rdata), 32'h0E4);
        check("disp_ime_off", 32'(ime), 32'h0);
        idle(0, 16'h0);
        check("take_one_cycle", 32'(irq_take), 32'h0);

        // EI delay: armed boundary does not dispatch
        cyc(0, A_IF, 8'h00, 1, 0, 5'b0, 0, 0, 0, 0);
        cyc(0, 16'h0, 8'h00, 0, 0, 5'b00001, 0, 0, 0, 0);
        cyc(0, 16'h0, 8'h00, 0, 0, 5'b0, 1, 1, 0, 0);
        cyc(0, 16'h0, 8'h00, 0, 0, 5'b0, 1, 0, 0, 0);
        check("armed_ime", 32'(ime), 32'h0);
        cyc(0, 16'h0, 8'h00, 0, 0, 5'b0, 1, 0, 0, 0);
        check("armed_no_take", 32'(irq_take), 32'h0);
        check("ei_ime_on", 32'(ime), 32'h1);
        idle(0, 16'h0);
        check("ei_disp_take", 32'(irq_take), 32'h1);
        check("ei_disp_vector", 32'(irq_vector), 32'h0040);

        // Request beats a clearing bus write
        cyc(0, A_IF, 8'h00, 1, 0, 5'b00100, 0, 0, 0, 0);
        idle(1, A_IF);
        check("req_beats_write", 32'(bus_rdata), 32'h0E4);

        // Wake with IME off
        cyc(0, A_IF, 8'h00, 1, 0, 5'b0, 0, 0, 0, 0);
        cyc(0, A_IE, 8'h04, 1, 0, 5'b0, 0, 0, 0, 0);
        cyc(0, 16'h0, 8'h00, 0, 0, 5'b00100, 0, 0, 0, 0);
        idle(0, 16'h0);
        check("wake_lag", 32'(wake), 32'h0);
        idle(0, 16'h0);
        check("wake_set", 32'(wake), 32'h1);
        check("wake_no_take", 32'(irq_take), 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] a;
            logic        b;
            case ($urandom_range(0, 3))
                0:       a = A_IF;
                1:       a = A_IE;
                default: a = 16'($urandom);
            endcase
            b = 1'($urandom);
            cyc($urandom_range(0, 199) == 0, a, 8'($urandom), $urandom_range(0, 3) == 0,
                1'($urandom), ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0,
                b, b && ($urandom_range(0, 5) == 0), $urandom_range(0, 11) == 0,
                b && ($urandom_range(0, 9) == 0));
        end

        // Eight sources: top index and held request after dispatch
        cyc8(1, 16'h0, 8'h00, 0, 0, 8'h00, 0, 0);
        cyc8(0, A_IE, 8'h80, 1, 0, 8'h00, 0, 0);
        cyc8(0, 16'h0, 8'h00, 0, 0, 8'h00, 1, 1);
        cyc8(0, 16'h0, 8'h00, 0, 0, 8'h80, 0, 0);
        cyc8(0, 16'h0, 8'h00, 0, 0, 8'h80, 1, 0);
        cyc8(0, A_IF, 8'h00, 0, 1, 8'h80, 0, 0);
`ifdef INTC_IRQ_EDGE_DETECT_EN
        exp_held = 8'h00;
`else
        exp_held = 8'h80;
`endif
        check("s8_take", 32'(d8_take), 32'h1);
        check("s8_index", 32'(d8_index), 32'h7);
        check("s8_vector", 32'(d8_vector), 32'h0078);
        check("s8_if_after_clear", 32'(d8_rdata), 32'(exp_held));
        cyc8(0, A_IF, 8'h00, 0, 1, 8'h80, 0, 0);
        check("s8_take_drop", 32'(d8_take), 32'h0);
        check("s8_if_held", 32'(d8_rdata), 32'(exp_held));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
